mux_pipe_n: RTL and testbench

- Parametrised N-way, WIDTH-bit selector with a registered output stage and valid/ready handshake on both sides.
- Generalises the datapath 2:1 select to NUM_IN sources.
- Adds a 2-entry skid buffer so a stalled consumer never forces a combinational ready path back to the producer.
- Used between pipeline stages of the MIPS CPU wherever a multi-source operand choice must be registered, e.g. forwarding select ahead of the EX stage.

---
 rtl/mux_pipe_n.sv | 124 ++++++++++++
 tb/tb_mux_pipe_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_n.sv
// N-way registered selector with valid/ready handshake and a 2-entry skid buffer.
// Optional output-transfer counter enabled by defining MUX_PIPE_N_XFER_CNT_EN.
module mux_pipe_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [31:0]             xfer_cnt
);

  logic [WIDTH-1:0] src [NUM_IN];
  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;

  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             in_ready_reg, in_ready_next;
  logic             sel_err_reg, sel_err_next;
  logic             accept;
  logic             main_free;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
      assign src[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects yield zero rather than aliasing onto a real source.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = src[k];
        sel_ok   = 1'b1;
      end
    end
  end

  assign accept    = in_valid && in_ready_reg;
  assign main_free = out_ready || !out_valid_reg;

  always_comb begin
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        out_data_next   = skid_data_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_data_next  = sel_data;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_data_next  = sel_data;
      skid_valid_next = 1'b1;
    end
    // Ready is registered so the consumer's ready never reaches the producer combinationally.
    in_ready_next = !skid_valid_next;
    sel_err_next  = sel_err_reg || (accept && !flush && !sel_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      sel_err_reg    <= 1'b0;
    end else begin
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= in_ready_next;
      sel_err_reg    <= sel_err_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;
  assign sel_err   = sel_err_reg;

`ifdef MUX_PIPE_N_XFER_CNT_EN
  logic [31:0] xfer_cnt_reg;

  // Counts consumer handshakes, including one that coincides with a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: a vector table plus hand sequences for reset,
// select error, mid-operation reset and transfer counting.
module tb_mux_pipe_n;

  localparam int W = 8;
`ifdef MUX_PIPE_N_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        in_valid, flush, out_ready;

  logic [W-1:0] out_data4, out_data3;
  logic         out_valid4, out_valid3, in_ready4, in_ready3, sel_err4, sel_err3;
  logic [31:0]  xfer_cnt4, xfer_cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .flush(flush), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .sel_err(sel_err4), .xfer_cnt(xfer_cnt4)
  );

  mux_pipe_n #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data[23:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .sel_err(sel_err3), .xfer_cnt(xfer_cnt3)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] din;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic [7:0]  eod;
    logic        eir;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
    return CNT_EN ? c : 32'd0;
  endfunction

  initial begin
    // inputs, then expected out_valid/out_data/in_ready/xfer_cnt after the edge
    vecs[0]  = '{1'b1, 2'd0, 32'hD3C2B1A0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b1, 32'd0};
    vecs[1]  = '{1'b1, 2'd1, 32'hD3C2B1A0, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b1, 32'd1};
    vecs[2]  = '{1'b1, 2'd2, 32'hD3C2B1A0, 1'b1, 1'b0, 1'b1, 8'hC2, 1'b1, 32'd2};
    vecs[3]  = '{1'b1, 2'd3, 32'hD3C2B1A0, 1'b1, 1'b0, 1'b1, 8'hD3, 1'b1, 32'd3};
    vecs[4]  = '{1'b0, 2'd0, 32'hD3C2B1A0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'd4};
    vecs[5]  = '{1'b1, 2'd0, 32'h00000011, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 32'd4};
    vecs[6]  = '{1'b1, 2'd0, 32'h00000022, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 32'd4};
    vecs[7]  = '{1'b0, 2'd0, 32'h00000077, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 2'd0, 32'h00000077, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 32'd5};
    vecs[9]  = '{1'b0, 2'd0, 32'h00000077, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'd6};
    vecs[10] = '{1'b1, 2'd0, 32'h00000033, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 32'd6};
    vecs[11] = '{1'b1, 2'd0, 32'h00000044, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 32'd6};
    vecs[12] = '{1'b0, 2'd0, 32'h00000000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'd6};
    vecs[13] = '{1'b1, 2'd0, 32'h00000055, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 32'd6};
    vecs[14] = '{1'b0, 2'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'd7};
    vecs[15] = '{1'b1, 2'd0, 32'h00000066, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'd7};
    vecs[16] = '{1'b0, 2'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'd7};

    do_reset();
    check("reset out_valid", 32'(out_valid4), 32'd0);
    check("reset out_data", 32'(out_data4), 32'd0);
    check("reset in_ready", 32'(in_ready4), 32'd1);
    check("reset sel_err", 32'(sel_err4), 32'd0);
    check("reset xfer_cnt", xfer_cnt4, 32'd0);
    $display("reset: ov=%0b od=0x%0h ir=%0b", out_valid4, out_data4, in_ready4);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid4), 32'(vecs[i].eov));
      if (vecs[i].eov)
        check($sformatf("vec%0d out_data", i), 32'(out_data4), 32'(vecs[i].eod));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready4), 32'(vecs[i].eir));
      check($sformatf("vec%0d xfer_cnt", i), xfer_cnt4, exp_cnt(vecs[i].ecnt));
      $display("vec%0d: v=%0b sel=%0d fl=%0b ordy=%0b -> ov=%0b od=0x%0h ir=%0b cnt=%0d",
               i, vecs[i].v, vecs[i].sel, vecs[i].fl, vecs[i].ordy,
               out_valid4, out_data4, in_ready4, xfer_cnt4);
    end

    // Out-of-range select on the 3-source instance.
    do_reset();
    drive(1'b1, 2'd3, 32'hD3C2B1A0, 1'b1, 1'b0);
    tick();
    check("selerr out_valid", 32'(out_valid3), 32'd1);
    check("selerr out_data", 32'(out_data3), 32'd0);
    check("selerr sel_err", 32'(sel_err3), 32'd1);
    check("selerr 4-way clean", 32'(sel_err4), 32'd0);
    check("selerr 4-way data", 32'(out_data4), 32'hD3);
    $display("sel_err beat: od3=0x%0h err3=%0b od4=0x%0h err4=%0b", out_data3, sel_err3, out_data4, sel_err4);
    drive(1'b1, 2'd1, 32'hD3C2B1A0, 1'b1, 1'b0);
    tick();
    check("selerr legal data", 32'(out_data3), 32'hB1);
    check("selerr sticky", 32'(sel_err3), 32'd1);
    drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    tick();
    check("selerr sticky idle", 32'(sel_err3), 32'd1);
    $display("sel_err legal beat: od3=0x%0h err3=%0b", out_data3, sel_err3);

    // Reset while full and stalled, with a beat offered during reset.
    do_reset();
    drive(1'b1, 2'd0, 32'h00000088, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd0, 32'h00000099, 1'b0, 1'b0);
    tick();
    check("full before rst in_ready", 32'(in_ready4), 32'd0);
    rst = 1'b1;
    drive(1'b1, 2'd1, 32'h0000AA00, 1'b0, 1'b0);
    tick();
    check("midrst out_valid", 32'(out_valid4), 32'd0);
    check("midrst out_data", 32'(out_data4), 32'd0);
    check("midrst in_ready", 32'(in_ready4), 32'd1);
    tick();
    check("rst hold no capture", 32'(out_valid4), 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    tick();
    check("after rst out_valid", 32'(out_valid4), 32'd0);
    check("after rst in_ready", 32'(in_ready4), 32'd1);
    $display("mid-reset: ov=%0b od=0x%0h ir=%0b", out_valid4, out_data4, in_ready4);

    // Five transfers, then one beat discarded by flush.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i % 4), 32'hD3C2B1A0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd0, 32'h000000EE, 1'b0, 1'b0);
    tick();
    check("cnt stalled beat", 32'(out_valid4), 32'd1);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    tick();
    check("cnt flushed out_valid", 32'(out_valid4), 32'd0);
    check("cnt after flush", xfer_cnt4, exp_cnt(32'd5));
    $display("xfer count: cnt=%0d", xfer_cnt4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
